keypad_bcd_entry: RTL and testbench

- Scans a 4x4 matrix keypad, synchronises and debounces the key lines, and decodes each press to a 4-bit key code.
- Digit keys shift into a 4-digit BCD entry register whose BCD0..BCD3 outputs drive the existing 4-digit seven-segment display driver directly.
- Input-side counterpart of the display path: this block scans a matrix inward to BCD, the display driver multiplexes BCD outward to segments.

---
 rtl/keypad_bcd_entry_if.sv | 35 +++
 rtl/keypad_bcd_entry.sv | 190 +++++++++++++++++++
 tb/tb_keypad_bcd_entry.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_bcd_entry_if.sv
// rtl/keypad_bcd_entry_if.sv - keypad matrix and BCD entry signal bundle
interface keypad_bcd_entry_if;
   logic [3:0] ROW;
   logic [3:0] COL;
   logic [3:0] BCD0;
   logic [3:0] BCD1;
   logic [3:0] BCD2;
   logic [3:0] BCD3;
   logic       key_valid;
   logic [3:0] key_code;

   // keypad/display side: drives the row lines, observes everything else
   modport master (
      output ROW,
      input  COL,
      input  BCD0,
      input  BCD1,
      input  BCD2,
      input  BCD3,
      input  key_valid,
      input  key_code
   );

   // scanner side
   modport slave (
      input  ROW,
      output COL,
      output BCD0,
      output BCD1,
      output BCD2,
      output BCD3,
      output key_valid,
      output key_code
   );
endinterface

// File: rtl/keypad_bcd_entry.sv
// rtl/keypad_bcd_entry.sv - 4x4 keypad scanner with debounced BCD digit entry (option: KEYPAD_BLANK_LEAD_EN)
module keypad_bcd_entry #(
   parameter int SCAN_DIV       = 13,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   keypad_bcd_entry_if.slave kif
);

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS - 1);
   localparam logic [SCAN_DIV-1:0] TICK_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   logic [3:0]          row_s1;
   logic [3:0]          row_s2;
   logic [SCAN_DIV-1:0] tick_cnt;
   logic                tick;
   state_t              state;
   logic [1:0]          col_idx;
   logic [1:0]          row_idx;
   logic [3:0]          db_cnt;
   logic [3:0]          col_q;
   logic [3:0]          code_q;
   logic                key_valid_q;
   logic [3:0]          dig0;
   logic [3:0]          dig1;
   logic [3:0]          dig2;
   logic [3:0]          dig3;
   logic                row_any;
   logic [1:0]          row_low;
   logic [3:0]          key_new;

   // active-low one-hot column drive for a column index
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // physical key layout: row-major, '*' = E, '#' = F
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0:    k = 4'd1;
         4'h1:    k = 4'd2;
         4'h2:    k = 4'd3;
         4'h3:    k = 4'd10;
         4'h4:    k = 4'd4;
         4'h5:    k = 4'd5;
         4'h6:    k = 4'd6;
         4'h7:    k = 4'd11;
         4'h8:    k = 4'd7;
         4'h9:    k = 4'd8;
         4'hA:    k = 4'd9;
         4'hB:    k = 4'd12;
         4'hC:    k = 4'd14;
         4'hD:    k = 4'd0;
         4'hE:    k = 4'd15;
         default: k = 4'd13;
      endcase
      return k;
   endfunction

   // two-flop synchroniser for the asynchronous row lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1 <= 4'h0;
         row_s2 <= 4'h0;
      end else begin
         row_s1 <= kif.ROW;
         row_s2 <= row_s1;
      end
   end

   // free-running scan prescaler; tick marks the edge on which it wraps to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else        tick_cnt <= tick_cnt + TICK_ONE;
   end

   assign tick = &tick_cnt;

   // lowest-index low row wins when several rows are pulled down together
   always_comb begin
      row_any = (row_s2 != 4'hF);
      row_low = 2'd0;
      if (!row_s2[0])      row_low = 2'd0;
      else if (!row_s2[1]) row_low = 2'd1;
      else if (!row_s2[2]) row_low = 2'd2;
      else if (!row_s2[3]) row_low = 2'd3;
   end

   assign key_new = key_map(row_idx, col_idx);

   // scan/debounce/held FSM with registered column drive, key outputs and digit store
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         row_idx     <= 2'd0;
         db_cnt      <= 4'd0;
         col_q       <= 4'b1110;
         code_q      <= 4'd0;
         key_valid_q <= 1'b0;
         dig0        <= 4'd0;
         dig1        <= 4'd0;
         dig2        <= 4'd0;
         dig3        <= 4'd0;
      end else begin
         key_valid_q <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (!row_any) begin
                     col_idx <= col_idx + 2'd1;
                     col_q   <= col_drive(col_idx + 2'd1);
                  end else begin
                     row_idx <= row_low;
                     db_cnt  <= 4'd0;
                     state   <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (row_any && (row_low == row_idx)) begin
                     if (db_cnt == DB_LAST) begin
                        key_valid_q <= 1'b1;
                        code_q      <= key_new;
                        db_cnt      <= 4'd0;
                        state       <= HELD;
                        if (key_new <= 4'd9) begin
                           dig3 <= dig2;
                           dig2 <= dig1;
                           dig1 <= dig0;
                           dig0 <= key_new;
                        end else if (key_new == 4'd10) begin
                           dig3 <= 4'd0;
                           dig2 <= 4'd0;
                           dig1 <= 4'd0;
                           dig0 <= 4'd0;
                        end else if (key_new == 4'd11) begin
                           dig0 <= dig1;
                           dig1 <= dig2;
                           dig2 <= dig3;
                           dig3 <= 4'd0;
                        end
                     end else begin
                        db_cnt <= db_cnt + 4'd1;
                     end
                  end else begin
                     // bounce or a different row: resume scanning on the same column
                     state <= SCAN;
                  end
               end
               HELD: begin
                  if (!row_any) begin
                     if (db_cnt == DB_LAST) begin
                        db_cnt  <= 4'd0;
                        state   <= SCAN;
                        col_idx <= col_idx + 2'd1;
                        col_q   <= col_drive(col_idx + 2'd1);
                     end else begin
                        db_cnt <= db_cnt + 4'd1;
                     end
                  end else begin
                     db_cnt <= 4'd0;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   assign kif.COL       = col_q;
   assign kif.key_valid = key_valid_q;
   assign kif.key_code  = code_q;
   assign kif.BCD0      = dig0;

`ifdef KEYPAD_BLANK_LEAD_EN
   // leading zeros shown as blank (F); the units digit always shows
   assign kif.BCD3 = (dig3 == 4'd0) ? 4'hF : dig3;
   assign kif.BCD2 = ({dig3, dig2} == 8'd0) ? 4'hF : dig2;
   assign kif.BCD1 = ({dig3, dig2, dig1} == 12'd0) ? 4'hF : dig1;
`else
   assign kif.BCD3 = dig3;
   assign kif.BCD2 = dig2;
   assign kif.BCD1 = dig1;
`endif

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb/tb_keypad_bcd_entry.sv - self-checking bench for keypad_bcd_entry
module tb_keypad_bcd_entry;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] keys = 16'h0;
   logic [3:0]  row_drv;
   int          passed = 0;
   int          total = 0;

   keypad_bcd_entry_if kif();

   keypad_bcd_entry #(.SCAN_DIV(2), .DEBOUNCE_SCANS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   // passive keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row_drv = 4'hF;
      for (int r = 0; r < 4; r++)
         row_drv[r] = ~|(keys[r*4 +: 4] & ~kif.COL);
   end
   assign kif.ROW = row_drv;

   typedef struct {
      int          r;
      int          c;
      logic [3:0]  code;
      logic [15:0] bcd;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [15:0] disp(input logic [15:0] s);
      logic [15:0] d;
      d = s;
`ifdef KEYPAD_BLANK_LEAD_EN
      if (s[15:12] == 4'd0) d[15:12] = 4'hF;
      if (s[15:8] == 8'd0)  d[11:8]  = 4'hF;
      if (s[15:4] == 12'd0) d[7:4]   = 4'hF;
`endif
      return d;
   endfunction

   function automatic logic [15:0] bcd_out();
      return {kif.BCD3, kif.BCD2, kif.BCD1, kif.BCD0};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_col(input logic [3:0] want);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (kif.COL == want) ok = 1'b1;
      end
      if (!ok) check("wait_col_timeout", 16'(kif.COL), 16'(want));
   endtask

   // press, hold 40 clk, release, watch 60 clk for the first column change
   task automatic press_release(input logic [15:0] mask, output int pulses,
                                output logic [3:0] code, output logic [3:0] col_after);
      logic [3:0] col_hold;
      bit         seen;
      pulses    = 0;
      code      = 4'h0;
      col_after = 4'h0;
      seen      = 1'b0;
      keys      = mask;
      repeat (40) begin
         @(negedge clk);
         if (kif.key_valid) begin
            pulses++;
            code = kif.key_code;
         end
      end
      col_hold = kif.COL;
      keys     = 16'h0;
      repeat (60) begin
         @(negedge clk);
         if (kif.key_valid) pulses++;
         if (!seen && kif.COL != col_hold) begin
            col_after = kif.COL;
            seen      = 1'b1;
         end
      end
   endtask

   initial begin
      int         pulses;
      logic [3:0] code;
      logic [3:0] col_after;
      logic [3:0] prev;
      int         changes;
      int         seq_err;
      int         idle_pulses;
      int         pb;
      int         ps;

      vecs[0]  = '{1, 2, 4'd6,  16'h0006};
      vecs[1]  = '{0, 0, 4'd1,  16'h0061};
      vecs[2]  = '{0, 1, 4'd2,  16'h0612};
      vecs[3]  = '{0, 2, 4'd3,  16'h6123};
      vecs[4]  = '{1, 0, 4'd4,  16'h1234};
      vecs[5]  = '{1, 1, 4'd5,  16'h2345};
      vecs[6]  = '{1, 3, 4'd11, 16'h0234};
      vecs[7]  = '{0, 3, 4'd10, 16'h0000};
      vecs[8]  = '{2, 3, 4'd12, 16'h0000};
      vecs[9]  = '{3, 1, 4'd0,  16'h0000};
      vecs[10] = '{2, 0, 4'd7,  16'h0007};
      vecs[11] = '{2, 2, 4'd9,  16'h0079};
      vecs[12] = '{3, 0, 4'd14, 16'h0079};
      vecs[13] = '{3, 2, 4'd15, 16'h0079};
      vecs[14] = '{3, 3, 4'd13, 16'h0079};
      vecs[15] = '{2, 1, 4'd8,  16'h0798};
      vecs[16] = '{1, 3, 4'd11, 16'h0079};

      // asynchronous reset values, checked before any clock edge acts
      #1 rst_n = 1'b0;
      #2;
      check("reset_col", 16'(kif.COL), 16'h000E);
      check("reset_bcd", bcd_out(), disp(16'h0000));
      check("reset_valid", 16'(kif.key_valid), 16'h0);
      check("reset_code", 16'(kif.key_code), 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // idle scan: column advances every 4 clk in order 0,1,2,3
      changes = 0;
      seq_err = 0;
      idle_pulses = 0;
      prev = kif.COL;
      repeat (32) begin
         @(negedge clk);
         if (kif.key_valid) idle_pulses++;
         if (kif.COL != prev) begin
            changes++;
            if (kif.COL != {prev[2:0], prev[3]}) seq_err++;
            prev = kif.COL;
         end
      end
      check("idle_col_changes", 16'(changes), 16'd8);
      check("idle_col_order", 16'(seq_err), 16'd0);
      check("idle_no_valid", 16'(idle_pulses), 16'd0);
      check("idle_bcd", bcd_out(), disp(16'h0000));

      // key entry table
      for (int i = 0; i < 17; i++) begin
         press_release(16'h1 << (vecs[i].r * 4 + vecs[i].c), pulses, code, col_after);
         check($sformatf("vec%0d_pulses", i), 16'(pulses), 16'd1);
         check($sformatf("vec%0d_code", i), 16'(code), 16'(vecs[i].code));
         check($sformatf("vec%0d_bcd", i), bcd_out(), disp(vecs[i].bcd));
         check($sformatf("vec%0d_next_col", i), 16'(col_after),
               16'(4'b1111 ^ (4'b0001 << ((vecs[i].c + 1) % 4))));
      end
      check("table_last_code", 16'(kif.key_code), 16'd11);

      // bounce on key 5: low one tick, high one tick, then stable
      wait_col(4'b1110);
      wait_col(4'b1101);
      pb = 0;
      ps = 0;
      code = 4'h0;
      keys = 16'h1 << 5;
      repeat (4) begin @(negedge clk); if (kif.key_valid) pb++; end
      keys = 16'h0;
      repeat (4) begin @(negedge clk); if (kif.key_valid) pb++; end
      keys = 16'h1 << 5;
      repeat (40) begin
         @(negedge clk);
         if (kif.key_valid) begin ps++; code = kif.key_code; end
      end
      keys = 16'h0;
      repeat (40) begin @(negedge clk); if (kif.key_valid) ps++; end
      check("bounce_no_early_pulse", 16'(pb), 16'd0);
      check("bounce_one_pulse", 16'(ps), 16'd1);
      check("bounce_code", 16'(code), 16'd5);
      check("bounce_bcd", bcd_out(), disp(16'h0795));

      // r0 and r2 both low in column 1: row 0 wins
      press_release((16'h1 << 1) | (16'h1 << 9), pulses, code, col_after);
      check("multi_pulses", 16'(pulses), 16'd1);
      check("multi_code", 16'(code), 16'd2);
      check("multi_bcd", bcd_out(), disp(16'h7952));
      check("multi_next_col", 16'(col_after), 16'h000B);

      // reset asserted mid-debounce takes effect without a clock edge
      wait_col(4'b1110);
      wait_col(4'b1101);
      keys = (16'h1 << 1) | (16'h1 << 9);
      repeat (6) @(negedge clk);
      check("pre_reset_col_held", 16'(kif.COL), 16'h000D);
      rst_n = 1'b0;
      #1;
      check("async_reset_col", 16'(kif.COL), 16'h000E);
      check("async_reset_bcd", bcd_out(), disp(16'h0000));
      check("async_reset_valid", 16'(kif.key_valid), 16'h0);
      check("async_reset_code", 16'(kif.key_code), 16'h0);
      keys = 16'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // enter 0 then 7: leading-zero display depends on the blanking option
      press_release(16'h1 << 13, pulses, code, col_after);
      check("zero_code", 16'(code), 16'd0);
      check("zero_bcd", bcd_out(), disp(16'h0000));
      press_release(16'h1 << 8, pulses, code, col_after);
      check("seven_code", 16'(code), 16'd7);
      check("seven_bcd", bcd_out(), disp(16'h0007));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
